// File: rtl/chip8_timer_bank_pkg.sv
// chip8_timer_pkg: shared constants for the CHIP-8 timer bank.
//   CHANNEL_DT / CHANNEL_ST : channel indices of the classic delay and sound timers
//   DEFAULT_WIDTH           : counter width of the original machine
//   TICK_HZ                 : nominal tick rate of the external slow clock
//   sel_width()             : bit width of a channel select for a given channel count
package chip8_timer_pkg;

  localparam int CHANNEL_DT       = 0;
  localparam int CHANNEL_ST       = 1;
  localparam int DEFAULT_CHANNELS = 2;
  localparam int DEFAULT_WIDTH    = 8;
  localparam int TICK_HZ          = 60;

  // A single channel still gets a 1-bit select so the port never collapses.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/chip8_timer_bank_if.sv
// chip8_timer_bank_if: CPU-side register port of the timer bank.
//   wr_en/wr_sel/wr_data : load strobe, target channel, load value
//   rd_sel/rd_data       : read channel select and registered read data
// Handshake: the port is a single-cycle strobe with no back-pressure. A write
// is taken on every clk edge where wr_en is high (valid is wr_en, ready is
// permanently 1); rd_data returns the selected counter one cycle after rd_sel.
// master = CPU side, slave = timer bank.
interface chip8_timer_bank_if
  import chip8_timer_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH
);
  localparam int SEL_W = sel_width(CHANNELS);

  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [SEL_W-1:0] rd_sel;
  logic [WIDTH-1:0] rd_data;

  modport master (output wr_en, wr_sel, wr_data, rd_sel, input rd_data);
  modport slave  (input wr_en, wr_sel, wr_data, rd_sel, output rd_data);

endinterface

// File: rtl/chip8_timer_bank_tick_gen.sv
// chip8_tick_gen: raw tick source for the timer bank.
//   clk, rst_n  : system clock, async active-low reset
//   clk_60hz    : external slow square wave (used only when CLK_DIV == 0)
//   raw_tick_o  : one-cycle pulse per tick, before freeze gating
// CLK_DIV == 0: clk_60hz is synchronised, edge-detected, and the rising edge
// is registered, so raw_tick_o rises SYNC_STAGES+1 cycles after the input edge.
// CLK_DIV == N > 0: a prescaler counts 0..N-1 and raw_tick_o is high on the
// wrap cycle; N == 1 therefore ticks every cycle.
module chip8_tick_gen
  import chip8_timer_pkg::*;
#(
  parameter int CLK_DIV     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_60hz,
  output logic raw_tick_o
);

  // Fewer than two stages would not be a synchroniser.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  generate
    if (CLK_DIV == 0) begin : g_ext
      logic [SYNC_N-1:0] sync_q;
      logic              edge_q;
      logic              raw_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
          edge_q <= 1'b0;
          raw_q  <= 1'b0;
        end else begin
          sync_q <= {sync_q[SYNC_N-2:0], clk_60hz};
          edge_q <= sync_q[SYNC_N-1];
          raw_q  <= sync_q[SYNC_N-1] & ~edge_q;
        end
      end

      assign raw_tick_o = raw_q;
    end else begin : g_div
      localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;
      logic          wrap;
      logic          unused_60hz;

      assign unused_60hz = clk_60hz;
      assign wrap        = (pre_q == PW'(CLK_DIV - 1));
      assign pre_d       = wrap ? '0 : pre_q + 1'b1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      assign raw_tick_o = wrap;
    end
  endgenerate

endmodule

// File: rtl/chip8_timer_bank.sv
// chip8_timer_bank: CHANNELS saturating down-counters for the CHIP-8 core
// (channel 0 = delay timer, channel 1 = sound timer by default).
//   clk, rst_n : system clock, async active-low reset
//   clk_60hz   : external tick source (ignored when CLK_DIV > 0)
//   freeze     : discards ticks while high (debug halt); dropped, not deferred
//   bus        : CPU register port (chip8_timer_bank_if.slave)
//   tick       : registered pulse, aligned with the decrement it caused
//   expired    : per-channel pulse on a 1->0 decrement
//   sound      : high while any SOUND_MASK channel is nonzero
module chip8_timer_bank
  import chip8_timer_pkg::*;
#(
  parameter int                  CHANNELS    = DEFAULT_CHANNELS,
  parameter int                  WIDTH       = DEFAULT_WIDTH,
  parameter int                  CLK_DIV     = 0,
  parameter logic [CHANNELS-1:0] SOUND_MASK  = CHANNELS'(2'b10),
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_60hz,
  input  logic                freeze,
  chip8_timer_bank_if.slave   bus,
  output logic                tick,
  output logic [CHANNELS-1:0] expired,
  output logic                sound
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic                raw_tick;
  logic                accept;
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] expired_q, expired_d;
  logic [CHANNELS-1:0] nonzero_d;
  logic                tick_q;
  logic                sound_q, sound_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;

  chip8_tick_gen #(
    .CLK_DIV     (CLK_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_60hz   (clk_60hz),
    .raw_tick_o (raw_tick)
  );

  assign accept = raw_tick & ~freeze;

  // A write to a channel masks that channel's tick only; selects beyond
  // CHANNELS match no channel, so such writes vanish.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]     = cnt_q[i];
      expired_d[i] = 1'b0;
      if (bus.wr_en && (bus.wr_sel == SEL_W'(i))) begin
        cnt_d[i] = bus.wr_data;
      end else if (accept && (cnt_q[i] != '0)) begin
        cnt_d[i]     = cnt_q[i] - 1'b1;
        expired_d[i] = (cnt_q[i] == WIDTH'(1));
      end
      nonzero_d[i] = (cnt_d[i] != '0);
    end
  end

  // Sound follows next-state values so it moves on the same edge as the counter.
  assign sound_d = |(nonzero_d & SOUND_MASK);

  // Read returns pre-update counter values; out-of-range selects read 0.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        rd_data_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      expired_q <= '0;
      tick_q    <= 1'b0;
      sound_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      expired_q <= expired_d;
      tick_q    <= accept;
      sound_q   <= sound_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign tick        = tick_q;
  assign expired     = expired_q;
  assign sound       = sound_q;

endmodule
